vga_rd_ctrl: RTL and testbench



---
 rtl/vga_pkg.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 62 ++++++
 rtl/vga_rd_ctrl.sv | 123 ++++++++++++
 tb/tb_vga_rd_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA read controller: default 640x480@60 timing,
// RGB565 field positions, colour-bar palette and the per-pixel pipeline payload.
package vga_pkg;

  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;

  localparam int unsigned RGB565_R_MSB = 15;
  localparam int unsigned RGB565_R_LSB = 11;
  localparam int unsigned RGB565_G_MSB = 10;
  localparam int unsigned RGB565_G_LSB = 5;
  localparam int unsigned RGB565_B_MSB = 4;
  localparam int unsigned RGB565_B_LSB = 0;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Timing/control bits that travel alongside each pixel through the delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic fetched;
  } vstage_t;

  // Widen each channel by replicating its MSBs into the new LSBs
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = d[RGB565_R_MSB:RGB565_R_LSB];
    g = d[RGB565_G_MSB:RGB565_G_LSB];
    b = d[RGB565_B_MSB:RGB565_B_LSB];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and stage-0 timing decode (sync, active window, frame start).
// With VGA_TEST_PATTERN_EN defined it also exports the active-pixel x position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT,
  localparam int unsigned HW      = $clog2(H_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hs0_c,
  output logic          vs0_c,
  output logic          de0_c,
  output logic          fs0_c
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [HW-1:0] x0_c
`endif
);

  localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned VW          = $clog2(V_TOTAL);
  localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Line counter wraps at H_TOTAL and steps the frame counter on each wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign hs0_c = (h_cnt < HW'(H_SYNC));
  assign vs0_c = (v_cnt < VW'(V_SYNC));
  assign de0_c = (h_cnt >= HW'(H_ACT_START)) && (h_cnt < HW'(H_ACT_END)) &&
                 (v_cnt >= VW'(V_ACT_START)) && (v_cnt < VW'(V_ACT_END));
  assign fs0_c = (h_cnt == HW'(H_ACT_START)) && (v_cnt == VW'(V_ACT_START));

`ifdef VGA_TEST_PATTERN_EN
  assign x0_c = h_cnt - HW'(H_ACT_START);
`endif

endmodule

// File: rtl/vga_rd_ctrl.sv
// VGA raster generator that pulls one RGB565 word per active pixel from the DDR read FIFO
// and drives RGB888 with aligned syncs; VGA_TEST_PATTERN_EN swaps the FIFO for colour bars.
module vga_rd_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC        = DEF_H_SYNC,
  parameter int unsigned H_BACK        = DEF_H_BACK,
  parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT       = DEF_H_FRONT,
  parameter int unsigned V_SYNC        = DEF_V_SYNC,
  parameter int unsigned V_BACK        = DEF_V_BACK,
  parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT       = DEF_V_FRONT,
  parameter bit          SYNC_POL      = 1'b0,
  parameter int unsigned FIFO_RD_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_valid,
  input  logic [FIFO_RD_WIDTH-1:0] rd_data,
  output logic                     rd_en,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic                     vga_de,
  output logic [23:0]              vga_rgb,
  output logic                     frame_start,
  output logic                     underflow
);

  logic    hs0_c, vs0_c, de0_c, fs0_c;
  vstage_t s0_c, s1, s2;
  logic [23:0] pix_c;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned HW    = $clog2(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] x0_c;
  logic [2:0]    bar0_c, bar1, bar2;
`endif

  vga_timing_gen #(
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT)
  ) u_timing (
    .clk   (clk),
    .rst   (rst),
    .hs0_c (hs0_c),
    .vs0_c (vs0_c),
    .de0_c (de0_c),
    .fs0_c (fs0_c)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .x0_c  (x0_c)
`endif
  );

`ifdef VGA_TEST_PATTERN_EN
  assign bar0_c = 3'(x0_c / HW'(BAR_W));
  assign s0_c   = '{hs: hs0_c, vs: vs0_c, de: de0_c, fs: fs0_c, fetched: de0_c};
`else
  assign s0_c   = '{hs: hs0_c, vs: vs0_c, de: de0_c, fs: fs0_c, fetched: de0_c & rd_valid};
`endif

  // Pixel source: FIFO word (black if it was never fetched) or the bar palette
  always_comb begin
    pix_c = '0;
`ifdef VGA_TEST_PATTERN_EN
    if (s2.de) pix_c = bar_colour(bar2);
`else
    if (s2.de && s2.fetched) pix_c = rgb565_to_888(16'(rd_data));
`endif
  end

  // Fetch at n+1, FIFO data at n+2, every VGA output registered at n+3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      rd_en       <= 1'b0;
      underflow   <= 1'b0;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      s1          <= s0_c;
      s2          <= s1;
`ifdef VGA_TEST_PATTERN_EN
      rd_en       <= 1'b0;
      underflow   <= 1'b0;
`else
      rd_en       <= de0_c & rd_valid;
      underflow   <= underflow | (de0_c & ~rd_valid);
`endif
      vga_hsync   <= s2.hs ? SYNC_POL : ~SYNC_POL;
      vga_vsync   <= s2.vs ? SYNC_POL : ~SYNC_POL;
      vga_de      <= s2.de;
      vga_rgb     <= pix_c;
      frame_start <= s2.fs;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar1 <= '0;
      bar2 <= '0;
    end else begin
      bar1 <= bar0_c;
      bar2 <= bar1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_rd_ctrl.sv
// Bench for vga_rd_ctrl on a reduced raster (H 4/4/8/4, V 2/2/4/2) with a 1-cycle-latency
// FIFO model; honours VGA_TEST_PATTERN_EN for the colour-bar build.
module tb_vga_rd_ctrl;

  localparam int HS = 4, HB = 4, HA = 8, HF = 4;
  localparam int VS = 2, VB = 2, VA = 4, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_en, vga_hsync, vga_vsync, vga_de, frame_start, underflow;
  logic [23:0] vga_rgb;

  vga_rd_ctrl #(
    .H_SYNC (HS), .H_BACK (HB), .H_ACTIVE (HA), .H_FRONT (HF),
    .V_SYNC (VS), .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF),
    .SYNC_POL (1'b0), .FIFO_RD_WIDTH (16)
  ) dut (
    .clk (clk), .rst (rst), .rd_valid (rd_valid), .rd_data (rd_data),
    .rd_en (rd_en), .vga_hsync (vga_hsync), .vga_vsync (vga_vsync),
    .vga_de (vga_de), .vga_rgb (vga_rgb), .frame_start (frame_start),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t        vecs [8];
  logic [23:0] bar_exp [8];
  logic        vhist [1024];
  logic [15:0] q [$];
  int          holes [3];
  int          checks = 0;
  int          errors = 0;
  int          cyc, first_hole, fs_first;
  int          rd_cnt [2];
  logic        holes_on, pend;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic is_active(input int k);
    int h, v;
    h = k % HT;
    v = (k / HT) % VT;
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  task automatic check_reset(input string name);
    check(name, 32'({vga_hsync, vga_vsync, vga_de, frame_start, rd_en, underflow, vga_rgb}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0}));
  endtask

  // Compare every output against the raster model for the current cycle
  task automatic check_cycle(input int c);
    int          k, h, v;
    logic        e_hs, e_vs, e_de, e_fs, e_rd, e_uf;
    logic [23:0] e_rgb;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0; e_rd = 1'b0;
    if (c >= 3) begin
      k = c - 3;
      h = k % HT;
      v = (k / HT) % VT;
      e_hs = !(h < HS);
      e_vs = !(v < VS);
      e_de = is_active(k);
      e_fs = (h == HS + HB) && (v == VS + VB);
`ifdef VGA_TEST_PATTERN_EN
      if (e_de) e_rgb = bar_exp[h - HS - HB];
`else
      if (e_de && vhist[k]) e_rgb = vecs[h - HS - HB].exp_rgb;
`endif
    end
`ifndef VGA_TEST_PATTERN_EN
    if (c >= 1) e_rd = is_active(c - 1) && vhist[c - 1];
`endif
    check("vga_out", 32'({vga_hsync, vga_vsync, vga_de, frame_start, vga_rgb}),
          32'({e_hs, e_vs, e_de, e_fs, e_rgb}));
    check("rd_en", 32'(rd_en), 32'(e_rd));
`ifdef VGA_TEST_PATTERN_EN
    check("underflow", 32'(underflow), 32'(0));
`else
    if (first_hole < 0 || c <= first_hole) begin
      check("underflow", 32'(underflow), 32'(0));
    end else if (c >= first_hole + 3) begin
      e_uf = 1'b1;
      check("underflow", 32'(underflow), 32'(e_uf));
    end
`endif
  endtask

  // One cycle at the negedge: check, service the FIFO model, drive rd_valid
  task automatic step();
    int   h;
    logic val;
    check_cycle(cyc);
    if (rd_en && cyc >= 1 && cyc <= FT) rd_cnt[0]++;
    if (rd_en && cyc > FT && cyc <= 2 * FT) rd_cnt[1]++;
    if (frame_start && fs_first < 0) fs_first = cyc;
    if (pend) begin
      check("fifo_nonempty", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) rd_data = q.pop_front();
    end
    pend = rd_en;
    val = 1'b1;
    if (holes_on) begin
      foreach (holes[i]) if (holes[i] == cyc) val = 1'b0;
    end
    rd_valid = val;
    vhist[cyc] = val;
    h = cyc % HT;
    if (val && is_active(cyc)) q.push_back(vecs[h - HS - HB].data);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    step();
  endtask

  initial begin
    vecs[0] = '{16'hF800, 24'hFF0000};
    vecs[1] = '{16'h07E0, 24'h00FF00};
    vecs[2] = '{16'h001F, 24'h0000FF};
    vecs[3] = '{16'hFFFF, 24'hFFFFFF};
    vecs[4] = '{16'h8410, 24'h848284};
    vecs[5] = '{16'h0841, 24'h080808};
    vecs[6] = '{16'h1234, 24'h1045A5};
    vecs[7] = '{16'hABCD, 24'hAD796B};
    bar_exp = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    // Line 0 pixel 3 of frame 1, plus pixels 5 and 6 of its line 2
    holes = '{2 * FT / 2 + 4 * HT + 8 + 3, FT + 6 * HT + 8 + 5, FT + 6 * HT + 8 + 6};
    rd_cnt = '{0, 0};
    rst = 1'b1; rd_valid = 1'b0; rd_data = '0; pend = 1'b0;
    holes_on = 1'b0; first_hole = -1; fs_first = -1; cyc = 0;

    repeat (10) begin
      @(negedge clk);
      check_reset("reset_hold");
    end

    // Run 1: two full frames with rd_valid holes in the second, into frame 2
    rst = 1'b0; cyc = 0; holes_on = 1'b1; first_hole = holes[0];
    step();
    repeat (2 * FT + 5 * HT + 11) tick();
`ifdef VGA_TEST_PATTERN_EN
    check("rd_cnt_frame0", 32'(rd_cnt[0]), 32'(0));
    check("rd_cnt_frame1", 32'(rd_cnt[1]), 32'(0));
`else
    check("rd_cnt_frame0", 32'(rd_cnt[0]), 32'(HA * VA));
    check("rd_cnt_frame1", 32'(rd_cnt[1]), 32'(HA * VA - 3));
`endif
    check("fs_first_run1", 32'(fs_first), 32'((VS + VB) * HT + HS + HB + 3));
    check("de_before_mid_rst", 32'(vga_de), 32'(1));

    // Mid-line reset: outputs drop to reset values without waiting for a clock
    rst = 1'b1;
    #1;
    check_reset("reset_mid");
    q.delete(); pend = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    check_reset("reset_mid_hold");

    // Run 2: raster restarts from zero, no stale FIFO data, underflow cleared
    rst = 1'b0; cyc = 0; holes_on = 1'b0; first_hole = -1; fs_first = -1;
    step();
    repeat (FT + 60) tick();
    check("fs_after_reset", 32'(fs_first), 32'((VS + VB) * HT + HS + HB + 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
